// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter steering the AW/W/B handshakes of 2**M_WIDTH masters onto one bus write path.
// Optional watchdog enabled by defining AXI_WR_ARB_TIMEOUT_EN.
module axi_wr_arbiter #(
  parameter  int M_WIDTH        = 2,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int N              = 1 << M_WIDTH,
  localparam int IDW            = (M_WIDTH > 0) ? M_WIDTH : 1
) (
  input  logic           BUS_CLK,
  input  logic           BUS_RST,
  input  logic [N-1:0]   M_AWVALID,
  output logic [N-1:0]   M_AWREADY,
  input  logic [N-1:0]   M_WVALID,
  input  logic [N-1:0]   M_WLAST,
  output logic [N-1:0]   M_WREADY,
  output logic [N-1:0]   M_BVALID,
  input  logic [N-1:0]   M_BREADY,
  output logic           S_AWVALID,
  input  logic           S_AWREADY,
  output logic           S_WVALID,
  output logic           S_WLAST,
  input  logic           S_WREADY,
  input  logic           S_BVALID,
  output logic           S_BREADY,
  output logic [IDW-1:0] GRANT_ID,
  output logic           GRANT_VLD,
  output logic           TIMEOUT_ERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   grant_oh;
  logic           aw_hs, w_hs, b_hs;
  logic           timeout_hit;

  // First requester at or after ptr, scanning cyclically.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] req, input logic [IDW-1:0] ptr);
    logic [IDW-1:0] idx;
    rr_pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] g);
    next_id = IDW'((int'(g) + 1) % N);
  endfunction

  assign grant_oh  = N'(1) << grant_id_q;
  assign GRANT_ID  = grant_id_q;
  assign GRANT_VLD = (state_q != ST_IDLE) && !BUS_RST;

  assign aw_hs = S_AWVALID & S_AWREADY;
  assign w_hs  = S_WVALID & S_WREADY;
  assign b_hs  = S_BVALID & S_BREADY;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    M_AWREADY = '0;
    M_WREADY  = '0;
    M_BVALID  = '0;
    S_AWVALID = 1'b0;
    S_WVALID  = 1'b0;
    S_WLAST   = 1'b0;
    S_BREADY  = 1'b0;
    // Outputs are forced low during reset so no handshake completes in the abort cycle.
    if (!BUS_RST) begin
      unique case (state_q)
        ST_ADDR: begin
          S_AWVALID = |(M_AWVALID & grant_oh);
          M_AWREADY = grant_oh & {N{S_AWREADY}};
        end
        ST_DATA: begin
          S_WVALID = |(M_WVALID & grant_oh);
          S_WLAST  = |(M_WLAST & grant_oh);
          M_WREADY = grant_oh & {N{S_WREADY}};
        end
        ST_RESP: begin
          M_BVALID = grant_oh & {N{S_BVALID}};
          S_BREADY = |(M_BREADY & grant_oh);
        end
        default: ;
      endcase
    end
  end

`ifdef AXI_WR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // Idle cycles of the current grant; any handshake restarts the count.
  always_comb begin
    cnt_d       = '0;
    timeout_hit = 1'b0;
    if (GRANT_VLD && !(aw_hs || w_hs || b_hs)) begin
      cnt_d       = cnt_q + 1'b1;
      timeout_hit = (cnt_d == CNT_W'(TIMEOUT_CYCLES));
    end
    timeout_err_d = timeout_hit;
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign TIMEOUT_ERR = timeout_err_q && !BUS_RST;
`else
  assign timeout_hit = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|M_AWVALID) begin
          grant_id_d = rr_pick(M_AWVALID, ptr_q);
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: if (aw_hs) state_d = ST_DATA;
      ST_DATA: if (w_hs && S_WLAST) state_d = ST_RESP;
      ST_RESP: begin
        if (b_hs) begin
          state_d = ST_IDLE;
          ptr_d   = next_id(grant_id_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (timeout_hit) begin
      state_d = ST_IDLE;
      ptr_d   = next_id(grant_id_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: stimulus queues expected grants, W beats and B responses,
// a negedge monitor pops and compares them as the DUT presents handshakes.
module tb_axi_wr_arbiter;

  localparam int MW = 2;
  localparam int NM = 1 << MW;

  typedef struct packed {
    logic [MW-1:0] id;
    logic          last;
  } beat_t;

  logic          BUS_CLK;
  logic          BUS_RST;
  logic [NM-1:0] M_AWVALID, M_AWREADY, M_WVALID, M_WLAST, M_WREADY, M_BVALID, M_BREADY;
  logic          S_AWVALID, S_AWREADY, S_WVALID, S_WLAST, S_WREADY, S_BVALID, S_BREADY;
  logic [MW-1:0] GRANT_ID;
  logic          GRANT_VLD, TIMEOUT_ERR;

  axi_wr_arbiter #(.M_WIDTH(MW), .TIMEOUT_CYCLES(16)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WVALID(M_WVALID), .M_WLAST(M_WLAST), .M_WREADY(M_WREADY),
    .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WVALID(S_WVALID), .S_WLAST(S_WLAST), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .GRANT_ID(GRANT_ID), .GRANT_VLD(GRANT_VLD), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  int    n_cmp = 0;
  int    n_err = 0;
  int    n_pulse = 0;
  int    exp_grant[$];
  beat_t exp_beat[$];
  int    exp_b[$];

  logic [15:0] all_outs;
  assign all_outs = {M_AWREADY, M_WREADY, M_BVALID, S_AWVALID, S_WVALID, S_WLAST, S_BREADY};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: grant order/latency, W beats, B responses and output isolation.
  initial begin
    logic  prev_vld;
    int    lat;
    int    e;
    beat_t eb;
    prev_vld = 1'b0;
    lat      = 0;
    forever begin
      @(negedge BUS_CLK);
      if (BUS_RST) begin
        lat = 0;
      end else begin
        if (GRANT_VLD && !prev_vld) begin
          if (exp_grant.size() == 0) check("grant_unexpected", exp_grant.size(), 1);
          else begin
            e = exp_grant.pop_front();
            check("grant_id", GRANT_ID, e);
            check("grant_latency", lat, 1);
          end
          lat = 0;
        end else if (!GRANT_VLD && |M_AWVALID) begin
          lat++;
        end
        if (GRANT_VLD)
          check("non_granted_quiet", (M_AWREADY | M_WREADY | M_BVALID) & ~(4'b0001 << GRANT_ID), 0);
        else
          check("idle_outputs", all_outs, 0);
        if (S_WVALID && S_WREADY) begin
          if (exp_beat.size() == 0) check("beat_unexpected", exp_beat.size(), 1);
          else begin
            eb = exp_beat.pop_front();
            check("w_beat", {GRANT_ID, S_WLAST}, eb);
          end
        end
        if (S_BVALID && S_BREADY) begin
          if (exp_b.size() == 0) check("b_unexpected", exp_b.size(), 1);
          else begin
            e = exp_b.pop_front();
            check("b_route", {M_BVALID, GRANT_ID}, {4'b0001 << e, e[MW-1:0]});
          end
        end
`ifdef AXI_WR_ARB_TIMEOUT_EN
        if (TIMEOUT_ERR) n_pulse++;
`else
        check("timeout_tied_low", TIMEOUT_ERR, 0);
`endif
      end
      prev_vld = GRANT_VLD;
    end
  end

  // Plays master `id` through one transaction; W is offered from the start so early beats must wait.
  task automatic serve(input int id, input int beats, input int wstall_beat, input int wstall_len,
                       input int bstall, input bit keep_aw);
    int beat  = 0;
    int stall = wstall_len;
    int bst   = bstall;
    bit aw_done = 0;
    bit b_done  = 0;
    exp_grant.push_back(id);
    for (int b = 0; b < beats; b++) exp_beat.push_back('{id: id[MW-1:0], last: (b == beats - 1)});
    exp_b.push_back(id);
    for (int cyc = 0; cyc < 200 && !b_done; cyc++) begin
      M_WVALID[id] = (beat < beats);
      M_WLAST[id]  = (beat == beats - 1);
      S_WREADY     = !(beat == wstall_beat && stall > 0);
      S_BVALID     = (beat == beats);
      M_BREADY[id] = (bst == 0);
      @(negedge BUS_CLK);
      if (!S_WREADY) begin
        check("wstall_wvalid_held", {GRANT_VLD, S_WVALID}, 2'b11);
        stall--;
      end
      if (S_BVALID && !M_BREADY[id]) begin
        check("bstall_bvalid_held", {GRANT_VLD, M_BVALID[id]}, 2'b11);
        bst--;
      end
      if (M_AWVALID[id] && M_AWREADY[id]) aw_done = 1;
      if (M_WVALID[id] && M_WREADY[id]) beat++;
      if (M_BVALID[id] && M_BREADY[id]) b_done = 1;
      @(posedge BUS_CLK); #1;
      if (aw_done && !keep_aw) M_AWVALID[id] = 1'b0;
    end
    check("txn_complete", b_done, 1);
    M_WVALID[id] = 1'b0;
    M_WLAST[id]  = 1'b0;
    M_BREADY[id] = 1'b0;
    S_BVALID     = 1'b0;
    S_WREADY     = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    bit hs;
    BUS_RST   = 1'b1;
    M_AWVALID = '0;
    M_WVALID  = '0;
    M_WLAST   = '0;
    M_BREADY  = '0;
    S_AWREADY = 1'b1;
    S_WREADY  = 1'b1;
    S_BVALID  = 1'b0;
    repeat (3) @(posedge BUS_CLK);
    #1 BUS_RST = 1'b0;
    @(negedge BUS_CLK);
    check("reset_state", {GRANT_VLD, GRANT_ID, TIMEOUT_ERR, all_outs}, 0);
    @(posedge BUS_CLK); #1;

    // Single master 1, 4-beat burst; PTR becomes 2.
    M_AWVALID = 4'b0010;
    serve(1, 4, -1, 0, 0, 0);

    // Master 2 moves PTR to 3, then 0 and 3 compete: 3 first, 0 after the wrap.
    M_AWVALID[2] = 1'b1;
    serve(2, 1, -1, 0, 0, 0);
    M_AWVALID = 4'b1001;
    serve(3, 2, -1, 0, 0, 0);
    serve(0, 1, -1, 0, 0, 0);

    // PTR=1: 6-beat burst, W ready low 5 cycles at beat 2, B ready low 3 cycles.
    M_AWVALID = 4'b0010;
    serve(1, 6, 2, 5, 3, 0);

    // PTR=2: reset after two beats of a burst on master 2.
    exp_grant.push_back(2);
    exp_beat.push_back('{id: 2'd2, last: 1'b0});
    exp_beat.push_back('{id: 2'd2, last: 1'b0});
    M_AWVALID[2] = 1'b1;
    M_WVALID[2]  = 1'b1;
    M_WLAST[2]   = 1'b0;
    n  = 0;
    hs = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(negedge BUS_CLK);
      if (M_AWVALID[2] && M_AWREADY[2]) hs = 1;
      if (M_WVALID[2] && M_WREADY[2]) n++;
      @(posedge BUS_CLK); #1;
      if (hs) M_AWVALID[2] = 1'b0;
    end
    check("rst_mid_beats_seen", n, 2);
    BUS_RST = 1'b1;
    @(negedge BUS_CLK);
    check("rst_cycle_outputs", {GRANT_VLD, all_outs}, 0);
    @(posedge BUS_CLK); #1;
    BUS_RST     = 1'b0;
    M_WVALID[2] = 1'b0;
    @(negedge BUS_CLK);
    check("rst_abort_idle", {GRANT_VLD, GRANT_ID, all_outs}, 0);
    @(posedge BUS_CLK); #1;

    // All four request continuously from PTR=0: 0,1,2,3,0.
    M_AWVALID = 4'b1111;
    serve(0, 1, -1, 0, 0, 1);
    serve(1, 2, -1, 0, 0, 1);
    serve(2, 1, -1, 0, 0, 1);
    serve(3, 3, -1, 0, 0, 1);
    serve(0, 1, -1, 0, 0, 1);
    M_AWVALID = '0;

`ifdef AXI_WR_ARB_TIMEOUT_EN
    // PTR=1: master 1 stalls after AW; pulse sits in the IDLE cycle 16 edges after the AW handshake edge.
    exp_grant.push_back(1);
    M_AWVALID = 4'b0110;
    hs = 0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge BUS_CLK);
      if (M_AWVALID[1] && M_AWREADY[1]) hs = 1;
    end
    check("to_aw_handshake", hs, 1);
    @(posedge BUS_CLK); #1;
    M_AWVALID[1] = 1'b0;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge BUS_CLK);
      k++;
      if (TIMEOUT_ERR) break;
    end
    check("to_delay", k, 17);
    check("to_idle", GRANT_VLD, 0);
    @(posedge BUS_CLK); #1;
    serve(2, 1, -1, 0, 0, 0);
`endif

    repeat (3) @(negedge BUS_CLK);
    check("sb_grant_empty", exp_grant.size(), 0);
    check("sb_beat_empty", exp_beat.size(), 0);
    check("sb_b_empty", exp_b.size(), 0);
`ifdef AXI_WR_ARB_TIMEOUT_EN
    check("to_pulse_count", n_pulse, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
